ram_delay_line: RTL and testbench

Sample-count delay line for wide data words, built on an inferred RAM circular buffer instead of a register shift chain. It sits in the long-step delay path of the AIS frame detector's data-delay stage. It advances only on cycles where the input enable (upstream sample valid) is high, so the delay is measured in accepted samples, not clock cycles.

---
 rtl/ram_delay_line_if.sv | 11 +
 rtl/ram_delay_line.sv | 81 ++++++++
 tb/tb_ram_delay_line.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ram_delay_line_if.sv
// rtl/ram_delay_line_if.sv - sample stream into and delayed word out of ram_delay_line
interface ram_delay_line_if #(
  parameter int PAR_DATA_WIDTH = 32
);
  logic                      i_ena;
  logic [PAR_DATA_WIDTH-1:0] i_dat;
  logic [PAR_DATA_WIDTH-1:0] o_dat;

  modport master (output i_ena, output i_dat, input o_dat);
  modport slave  (input i_ena, input i_dat, output o_dat);
endinterface

// File: rtl/ram_delay_line.sv
// rtl/ram_delay_line.sv - enable-gated RAM circular-buffer delay line; option macro RAM_DELAY_FILL_MASK_EN
module ram_delay_line #(
  parameter int PAR_DATA_WIDTH = 32,
  parameter int PAR_DELAY_LEN  = 512
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ram_delay_line_if.slave   dl
);

  generate
    if (PAR_DELAY_LEN == 1) begin : g_reg
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          dl.o_dat <= '0;
        end else if (dl.i_ena) begin
          dl.o_dat <= dl.i_dat;
        end
      end
    end else begin : g_ram
      localparam int DEPTH = PAR_DELAY_LEN - 1;
      localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

      logic [PAR_DATA_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]          wr_ptr;
      logic                      take;

      assign take = dl.i_ena && !i_rst;

      // Memory is never reset; a dropped sample during reset must not be written.
      always_ff @(posedge i_clk) begin
        if (take) begin
          mem[wr_ptr] <= dl.i_dat;
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          wr_ptr <= '0;
        end else if (dl.i_ena) begin
          wr_ptr <= (wr_ptr == PTR_W'(PAR_DELAY_LEN - 2)) ? '0 : wr_ptr + 1'b1;
        end
      end

`ifdef RAM_DELAY_FILL_MASK_EN
      localparam int FILL_W = $clog2(PAR_DELAY_LEN);

      logic [FILL_W-1:0] fill_cnt;
      logic              filled;

      assign filled = (fill_cnt == FILL_W'(PAR_DELAY_LEN - 1));

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          fill_cnt <= '0;
        end else if (dl.i_ena && !filled) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end

      // Until every RAM word has been written since reset, emit zeros like a cleared shift chain.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          dl.o_dat <= '0;
        end else if (dl.i_ena) begin
          dl.o_dat <= filled ? mem[wr_ptr] : '0;
        end
      end
`else
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          dl.o_dat <= '0;
        end else if (dl.i_ena) begin
          dl.o_dat <= mem[wr_ptr];
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_delay_line.sv
// tb/tb_ram_delay_line.sv - scoreboard bench for ram_delay_line at LEN 4, 5 and 1
module tb_ram_delay_line;

  typedef struct {
    logic [15:0] v;
    bit          known;
  } ent_t;

`ifdef RAM_DELAY_FILL_MASK_EN
  localparam bit FILL_MASK = 1'b1;
`else
  localparam bit FILL_MASK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  ram_delay_line_if #(.PAR_DATA_WIDTH(8))  if4 ();
  ram_delay_line_if #(.PAR_DATA_WIDTH(16)) if5 ();
  ram_delay_line_if #(.PAR_DATA_WIDTH(8))  if1 ();

  ram_delay_line #(.PAR_DATA_WIDTH(8),  .PAR_DELAY_LEN(4)) dut4 (.i_clk(clk), .i_rst(rst0), .dl(if4.slave));
  ram_delay_line #(.PAR_DATA_WIDTH(16), .PAR_DELAY_LEN(5)) dut5 (.i_clk(clk), .i_rst(rst1), .dl(if5.slave));
  ram_delay_line #(.PAR_DATA_WIDTH(8),  .PAR_DELAY_LEN(1)) dut1 (.i_clk(clk), .i_rst(rst2), .dl(if1.slave));

  int   checks = 0;
  int   errors = 0;
  ent_t expq   [3][$];
  ent_t line_q [3][$];
  ent_t last   [3];
  bit   fired  [3];

  function automatic int len_of(int id);
    return (id == 0) ? 4 : (id == 1) ? 5 : 1;
  endfunction

  function automatic logic [15:0] mask_of(int id, logic [15:0] d);
    return (id == 1) ? d : {8'h00, d[7:0]};
  endfunction

  task automatic reset_line(int id);
    line_q[id].delete();
    for (int i = 0; i < len_of(id) - 1; i++) line_q[id].push_back('{16'h0, FILL_MASK});
  endtask

  // One clock of stimulus on DUT id; all other DUTs idle this cycle.
  task automatic tick(int id, bit r, bit e, logic [15:0] d);
    ent_t x;
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if4.i_ena = 1'b0; if5.i_ena = 1'b0; if1.i_ena = 1'b0;
    case (id)
      0: begin rst0 = r; if4.i_ena = e; if4.i_dat = d[7:0]; end
      1: begin rst1 = r; if5.i_ena = e; if5.i_dat = d;      end
      default: begin rst2 = r; if1.i_ena = e; if1.i_dat = d[7:0]; end
    endcase
    if (r) begin
      expq[id].push_back('{16'h0, 1'b1});
      reset_line(id);
    end else if (e) begin
      line_q[id].push_back('{mask_of(id, d), 1'b1});
      x = line_q[id].pop_front();
      expq[id].push_back(x);
    end
  endtask

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(int id, bit f, logic [15:0] act);
    ent_t e;
    if (f) begin
      if (expq[id].size() == 0) begin
        checks++; errors++;
        $display("FAIL dut%0d_sb: output event with empty scoreboard, got %0h expected none", id, act);
      end else begin
        e = expq[id].pop_front();
        last[id] = e;
        if (e.known) cmp($sformatf("dut%0d_out", id), act, e.v);
      end
    end else if (last[id].known) begin
      cmp($sformatf("dut%0d_hold", id), act, last[id].v);
    end
  endtask

  always @(posedge clk) begin
    fired[0] = rst0 | if4.i_ena;
    fired[1] = rst1 | if5.i_ena;
    fired[2] = rst2 | if1.i_ena;
  end

  always @(negedge clk) begin
    mon(0, fired[0], {8'h00, if4.o_dat});
    mon(1, fired[1], if5.o_dat);
    mon(2, fired[2], {8'h00, if1.o_dat});
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if4.i_ena = 1'b0; if5.i_ena = 1'b0; if1.i_ena = 1'b0;
    if4.i_dat = '0;   if5.i_dat = '0;   if1.i_dat = '0;
    for (int i = 0; i < 3; i++) begin
      last[i] = '{16'h0, 1'b0};
      fired[i] = 1'b0;
    end

    // Power-up reset, with enable high so that sample is dropped
    tick(0, 1, 1, 16'hAA);
    tick(1, 1, 1, 16'hAAAA);
    tick(2, 1, 1, 16'hAA);

    // LEN=4 continuous enables
    for (int i = 1; i <= 8; i++) tick(0, 0, 1, 16'(i));

    // LEN=4 gapped enables, outputs hold through idle cycles
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(0, 0, 1, 16'(i));
      for (int k = 0; k < (i % 3); k++) tick(0, 0, 0, 16'hEE);
    end

    // LEN=5 random enables and data (pointer wraps after index 3)
    tick(1, 1, 0, 0);
    for (int i = 0; i < 1000; i++) tick(1, 0, ($urandom_range(0, 3) != 0), 16'($urandom));

    // LEN=4 mid-stream reset with enable high
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) tick(0, 0, 1, 16'(i));
    tick(0, 1, 1, 16'h99);
    for (int i = 11; i <= 16; i++) tick(0, 0, 1, 16'(i));

    // LEN=1: output follows the latest enabled sample, holds when idle
    tick(2, 0, 1, 16'h05);
    tick(2, 0, 1, 16'h06);
    tick(2, 0, 0, 16'h07);
    tick(2, 0, 0, 16'h08);
    tick(2, 0, 1, 16'hFF);
    tick(2, 0, 0, 16'h00);
    tick(2, 0, 1, 16'h00);

    // LEN=4 refill after reset: 21 samples leave words 19,20,21 at addresses 0,1,2
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 21; i++) tick(0, 0, 1, 16'(i));
    tick(0, 1, 0, 0);
    if (!FILL_MASK) begin
      line_q[0].delete();
      line_q[0].push_back('{16'd19, 1'b1});
      line_q[0].push_back('{16'd20, 1'b1});
      line_q[0].push_back('{16'd21, 1'b1});
    end
    for (int i = 100; i <= 105; i++) tick(0, 0, 1, 16'(i));

    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (expq[i].size() != 0) begin
        errors++;
        $display("FAIL dut%0d_drain: %0d outputs pending, expected 0", i, expq[i].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
